// File: rtl/sort_iter_sorter.sv
// sort_iter_sorter: iterative bubble sorter time-sharing one min/max unit across all compare-swap steps.
// Define SORT_ITER_SORTER_EARLY_EXIT_EN to finish as soon as a full pass makes no swaps.
module sort_iter_sorter #(
    parameter int p_nbits  = 8,
    parameter int p_nelems = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        in_val,
    output logic                        in_rdy,
    input  logic [p_nelems*p_nbits-1:0] in_msg,
    output logic                        out_val,
    input  logic                        out_rdy,
    output logic [p_nelems*p_nbits-1:0] out_msg
);
    localparam int cw = $clog2(p_nelems) + 1;
    localparam logic [cw-1:0] last_p = cw'(p_nelems - 2);

    typedef enum logic [1:0] {IDLE, SORT, DONE} state_t;

    state_t state, state_n;
    logic [p_nbits-1:0] r [p_nelems];
    logic [cw-1:0] p, j, j1;
    logic [p_nbits-1:0] a, b, mn, mx;
    logic swap, pass_end, stop;

    // The single shared compare unit: operands are always the adjacent pair r[j], r[j+1]
    assign j1 = j + cw'(1);
    assign a = r[j[cw-2:0]];
    assign b = r[j1[cw-2:0]];
    assign swap = a > b;
    assign mn = swap ? b : a;
    assign mx = swap ? a : b;
    assign pass_end = j == last_p - p;

`ifdef SORT_ITER_SORTER_EARLY_EXIT_EN
    logic swapped;
    assign stop = pass_end && (p == last_p || !(swapped || swap));
    always_ff @(posedge clk) begin
        if (!reset_n || (state == IDLE && in_val))
            swapped <= 1'b0;
        else if (state == SORT)
            swapped <= pass_end ? 1'b0 : swapped | swap;
    end
`else
    assign stop = pass_end && p == last_p;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = in_val ? SORT : IDLE;
            SORT:    state_n = stop ? DONE : SORT;
            DONE:    state_n = out_rdy ? IDLE : DONE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int k = 0; k < p_nelems; k++)
                r[k] <= '0;
            p <= '0;
            j <= '0;
        end else if (state == IDLE && in_val) begin
            for (int k = 0; k < p_nelems; k++)
                r[k] <= in_msg[k*p_nbits +: p_nbits];
            p <= '0;
            j <= '0;
        end else if (state == SORT) begin
            r[j[cw-2:0]] <= mn;
            r[j1[cw-2:0]] <= mx;
            j <= pass_end ? '0 : j1;
            p <= (pass_end && !stop) ? p + cw'(1) : p;
        end
    end

    for (genvar i = 0; i < p_nelems; i++) begin : g_out
        assign out_msg[i*p_nbits +: p_nbits] = r[i];
    end

    assign in_rdy  = reset_n && state == IDLE;
    assign out_val = reset_n && state == DONE;
endmodule

// File: tb/tb_sort_iter_sorter.sv
// tb_sort_iter_sorter: scoreboard bench for the iterative sorter at N=4, 8-bit elements.
module tb_sort_iter_sorter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        in_val = 1'b1;
    logic        out_rdy = 1'b0;
    logic [31:0] in_msg = '0;
    logic        in_rdy, out_val;
    logic [31:0] out_msg;
    int          cyc = 0;
    int          n_tests = 0;
    int          n_fail = 0;
    logic [31:0] sb [$];

`ifdef SORT_ITER_SORTER_EARLY_EXIT_EN
    localparam bit ee = 1'b1;
`else
    localparam bit ee = 1'b0;
`endif

    sort_iter_sorter #(.p_nbits(8), .p_nelems(4)) dut (
        .clk(clk), .reset_n(reset_n), .in_val(in_val), .in_rdy(in_rdy), .in_msg(in_msg),
        .out_val(out_val), .out_rdy(out_rdy), .out_msg(out_msg)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] sw_sort(input logic [31:0] m);
        logic [7:0] e [4];
        logic [7:0] v;
        int k;
        logic [31:0] res;
        for (int i = 0; i < 4; i++) e[i] = m[i*8 +: 8];
        for (int i = 1; i < 4; i++) begin
            v = e[i];
            k = i - 1;
            while (k >= 0 && e[k] > v) begin
                e[k+1] = e[k];
                k--;
            end
            e[k+1] = v;
        end
        for (int i = 0; i < 4; i++) res[i*8 +: 8] = e[i];
        return res;
    endfunction

    // Called at a negedge; returns the cycle of the input handshake and leaves us one negedge later
    task automatic send(input logic [31:0] m, input bit hold, output int t);
        int w = 0;
        in_msg = m;
        in_val = 1'b1;
        while (!in_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (!in_rdy) begin
            n_fail++;
            $display("FAIL send_timeout: in_rdy=%b required 1", in_rdy);
        end
        t = cyc;
        @(negedge clk);
        in_val = hold;
    endtask

    task automatic wait_out(output int u);
        int w = 0;
        while (!out_val && w < 100) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (!out_val) begin
            n_fail++;
            $display("FAIL out_timeout: out_val=%b required 1", out_val);
        end
        u = cyc;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(negedge clk);
            n_tests += 2;
            if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL reset_in_rdy: got %b want 0", in_rdy); end
            if (out_val !== 1'b0) begin n_fail++; $display("FAIL reset_out_val: got %b want 0", out_val); end
        end
        reset_n = 1'b1;
        in_val = 1'b0;
        @(negedge clk);
        n_tests += 2;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL post_reset_in_rdy: got %b want 1", in_rdy); end
        if (out_msg !== 32'h0) begin n_fail++; $display("FAIL post_reset_out_msg: got %h want 0", out_msg); end
    endtask

    task automatic test_reverse();
        int t;
        logic [31:0] exp;
        out_rdy = 1'b1;
        send(32'h00010203, 1'b0, t);
        sb.push_back(sw_sort(32'h00010203));
        for (int c = 1; c <= 7; c++) begin
            n_tests += 2;
            if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL rev_in_rdy t+%0d: got %b want 0", c, in_rdy); end
            if (out_val !== (c == 7)) begin n_fail++; $display("FAIL rev_out_val t+%0d: got %b want %b", c, out_val, c == 7); end
            if (c == 7) begin
                exp = sb.pop_front();
                n_tests += 2;
                if (out_msg !== exp) begin n_fail++; $display("FAIL rev_data: got %h want %h", out_msg, exp); end
                if (out_msg !== 32'h03020100) begin n_fail++; $display("FAIL rev_const: got %h want 03020100", out_msg); end
            end
            @(negedge clk);
        end
        n_tests++;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL rev_in_rdy_after: got %b want 1", in_rdy); end
    endtask

    task automatic test_latency_classes();
        logic [31:0] pats [3] = '{32'h007F00FF, 32'h04030201, 32'h55555555};
        int want [3];
        int t, u;
        logic [31:0] exp;
        want[0] = 7;
        want[1] = ee ? 4 : 7;
        want[2] = ee ? 4 : 7;
        out_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            send(pats[i], 1'b0, t);
            sb.push_back(sw_sort(pats[i]));
            wait_out(u);
            exp = sb.pop_front();
            n_tests += 2;
            if (u - t != want[i]) begin n_fail++; $display("FAIL latency_%0d: got %0d want %0d", i, u - t, want[i]); end
            if (out_msg !== exp) begin n_fail++; $display("FAIL data_%0d: got %h want %h", i, out_msg, exp); end
            @(negedge clk);
        end
        n_tests++;
        if (sw_sort(pats[0]) !== 32'hFF7F0000) begin n_fail++; $display("FAIL dup_model: got %h want ff7f0000", sw_sort(pats[0])); end
    endtask

    task automatic test_backpressure();
        int t, u;
        logic [31:0] m, m0, exp;
        out_rdy = 1'b0;
        m = $urandom;
        send(m, 1'b0, t);
        sb.push_back(sw_sort(m));
        wait_out(u);
        m0 = out_msg;
        exp = sb.pop_front();
        n_tests++;
        if (m0 !== exp) begin n_fail++; $display("FAIL bp_data: got %h want %h", m0, exp); end
        for (int c = 0; c < 5; c++) begin
            in_val = 1'b1;
            in_msg = $urandom;
            n_tests += 3;
            if (out_val !== 1'b1) begin n_fail++; $display("FAIL bp_out_val %0d: got %b want 1", c, out_val); end
            if (out_msg !== exp) begin n_fail++; $display("FAIL bp_stable %0d: got %h want %h", c, out_msg, exp); end
            if (in_rdy !== 1'b0) begin n_fail++; $display("FAIL bp_in_rdy %0d: got %b want 0", c, in_rdy); end
            @(negedge clk);
        end
        in_val = 1'b0;
        out_rdy = 1'b1;
        @(negedge clk);
        n_tests += 2;
        if (in_rdy !== 1'b1) begin n_fail++; $display("FAIL bp_release_in_rdy: got %b want 1", in_rdy); end
        if (out_val !== 1'b0) begin n_fail++; $display("FAIL bp_release_out_val: got %b want 0", out_val); end
    endtask

    task automatic test_back_to_back();
        int t, u, prev_t;
        logic [31:0] m, exp;
        out_rdy = 1'b1;
        prev_t = 0;
        for (int b = 0; b < 3; b++) begin
            m = $urandom;
            send(m, 1'b1, t);
            sb.push_back(sw_sort(m));
            if (b > 0) begin
                n_tests++;
                if (ee ? (t - prev_t < 5 || t - prev_t > 8) : (t - prev_t != 8)) begin
                    n_fail++;
                    $display("FAIL b2b_in_to_in_%0d: got %0d want 8", b, t - prev_t);
                end
            end
            wait_out(u);
            exp = sb.pop_front();
            n_tests += 2;
            if (ee ? (u - t < 4 || u - t > 7) : (u - t != 7)) begin n_fail++; $display("FAIL b2b_latency_%0d: got %0d want 7", b, u - t); end
            if (out_msg !== exp) begin n_fail++; $display("FAIL b2b_data_%0d: got %h want %h", b, out_msg, exp); end
            prev_t = t;
        end
        in_val = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int t, u;
        bit seen = 1'b0;
        logic [31:0] m, exp;
        out_rdy = 1'b1;
        send(32'h10203040, 1'b0, t);
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_val) seen = 1'b1;
        end
        n_tests += 2;
        if (seen) begin n_fail++; $display("FAIL midreset_out_val: got 1 want 0"); end
        if (out_msg !== 32'h0) begin n_fail++; $display("FAIL midreset_cleared: got %h want 0", out_msg); end
        m = 32'h8001FE7F;
        send(m, 1'b0, t);
        sb.push_back(sw_sort(m));
        wait_out(u);
        exp = sb.pop_front();
        n_tests++;
        if (out_msg !== exp) begin n_fail++; $display("FAIL midreset_next_data: got %h want %h", out_msg, exp); end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_reverse();
        test_latency_classes();
        test_backpressure();
        test_back_to_back();
        test_mid_reset();
        n_tests++;
        if (sb.size() != 0) begin n_fail++; $display("FAIL scoreboard_leftover: got %0d want 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
